fetch_issue_buffer: RTL and testbench

- Sits directly downstream of instruction fetch and upstream of dual-issue decode.
- Captures each fetched pair (pc, instruction1, instruction2) into a DEPTH-entry FIFO and presents the head pair to decode.
- Supports partial (single-slot) consumption, so decode can issue one instruction of a pair and keep the other.
- Back-pressures fetch through in_ready, which drives the fetch PC_enable, and discards all contents on a taken jump (flush).

---
 rtl/spu_pkg.sv | 17 +
 rtl/fib_storage.sv | 25 ++
 rtl/fetch_issue_buffer.sv | 115 +++++++++++
 tb/tb_fetch_issue_buffer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/spu_pkg.sv
// Shared types and constants for the fetch/issue front end.
package spu_pkg;

    parameter int PC_W = 32;
    localparam int INSTR_W = 32;

    localparam logic [1:0] CONS_NONE = 2'd0;
    localparam logic [1:0] CONS_ONE  = 2'd1;
    localparam logic [1:0] CONS_BOTH = 2'd2;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr1;
        logic [INSTR_W-1:0] instr2;
    } fib_entry_t;

endpackage

// File: rtl/fib_storage.sv
// Pair register file: one synchronous write port, one combinational read port.
module fib_storage #(
    parameter int  DEPTH   = 4,
    parameter int  AW      = $clog2(DEPTH),
    parameter type entry_t = spu_pkg::fib_entry_t
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  entry_t        wdata,
    input  logic [AW-1:0] raddr,
    output entry_t        rdata
);

    entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_issue_buffer.sv
// Pair FIFO between fetch and dual-issue decode with single-slot consumption
// (head half flag), back-pressure via in_ready and flush on redirect.
module fetch_issue_buffer
    import spu_pkg::*;
#(
    parameter int bitsize = 32,
    parameter int DEPTH   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [bitsize-1:0] in_pc,
    input  logic [INSTR_W-1:0] in_instr1,
    input  logic [INSTR_W-1:0] in_instr2,
    output logic               in_ready,
    input  logic               flush,
    output logic               out_valid1,
    output logic               out_valid2,
    output logic [bitsize-1:0] out_pc,
    output logic [INSTR_W-1:0] out_instr1,
    output logic [INSTR_W-1:0] out_instr2,
    input  logic [1:0]         out_consume
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [bitsize-1:0] pc;
        logic [INSTR_W-1:0] instr1;
        logic [INSTR_W-1:0] instr2;
    } entry_t;

    logic [AW-1:0] head, tail;
    logic [CW-1:0] count;
    logic          half;
    logic          has_entry;
    logic          push, pop, split;
    entry_t        wr_entry, head_entry;

    assign has_entry = (count != '0);
    // From state only: a pop while full frees the slot one cycle later.
    assign in_ready  = (count < CW'(DEPTH));
    assign wr_entry  = '{pc: in_pc, instr1: in_instr1, instr2: in_instr2};

    fib_storage #(
        .DEPTH   (DEPTH),
        .AW      (AW),
        .entry_t (entry_t)
    ) u_storage (
        .clk   (clk),
        .we    (push),
        .waddr (tail),
        .wdata (wr_entry),
        .raddr (head),
        .rdata (head_entry)
    );

    // BOTH on a half-consumed head only has one slot left, so it pops like ONE.
    always_comb begin
        push  = 1'b0;
        pop   = 1'b0;
        split = 1'b0;
        if (!flush) begin
            push = in_valid && in_ready;
            if (has_entry) begin
                case (out_consume)
                    CONS_NONE: ;
                    CONS_ONE: begin
                        if (half) pop   = 1'b1;
                        else      split = 1'b1;
                    end
                    CONS_BOTH: pop = 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            half  <= 1'b0;
        end else begin
            if (push) tail <= tail + AW'(1);
            if (pop)  head <= head + AW'(1);
            count <= count + CW'(push) - CW'(pop);
            if (pop)        half <= 1'b0;
            else if (split) half <= 1'b1;
        end
    end

    always_comb begin
        out_valid1 = 1'b0;
        out_valid2 = 1'b0;
        out_pc     = '0;
        out_instr1 = '0;
        out_instr2 = '0;
        if (has_entry) begin
            out_valid1 = 1'b1;
            if (half) begin
                out_pc     = head_entry.pc + bitsize'(4);
                out_instr1 = head_entry.instr2;
            end else begin
                out_valid2 = 1'b1;
                out_pc     = head_entry.pc;
                out_instr1 = head_entry.instr1;
                out_instr2 = head_entry.instr2;
            end
        end
    end

endmodule

// File: tb/tb_fetch_issue_buffer.sv
// Directed bench for fetch_issue_buffer: literal spot checks plus a
// scoreboard monitor that tracks every accepted pair and every consume.
module tb_fetch_issue_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_pc, in_instr1, in_instr2;
    logic        in_ready;
    logic        flush;
    logic        out_valid1, out_valid2;
    logic [31:0] out_pc, out_instr1, out_instr2;
    logic [1:0]  out_consume;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] i1;
        logic [31:0] i2;
    } pair_t;

    pair_t sb[$];
    bit    half_m = 1'b0;
    bit    mon_en = 1'b0;
    bit    rdy_m;
    pair_t hd;
    int    n_tests = 0;
    int    n_fail  = 0;

    fetch_issue_buffer #(.bitsize(32), .DEPTH(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_pc       (in_pc),
        .in_instr1   (in_instr1),
        .in_instr2   (in_instr2),
        .in_ready    (in_ready),
        .flush       (flush),
        .out_valid1  (out_valid1),
        .out_valid2  (out_valid2),
        .out_pc      (out_pc),
        .out_instr1  (out_instr1),
        .out_instr2  (out_instr2),
        .out_consume (out_consume)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset === 1'b0) begin
            assert (out_consume != 2'd3) else $error("illegal consume code driven");
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: compare presented outputs to the queue head, then apply the
    // inputs that the next rising edge will sample.
    always @(negedge clk) begin
        if (mon_en) begin
            rdy_m = (sb.size() < 4);
            check("mon in_ready", 64'(in_ready), 64'(rdy_m));
            if (sb.size() == 0) begin
                check("mon valid1 empty", 64'(out_valid1), 64'(0));
                check("mon valid2 empty", 64'(out_valid2), 64'(0));
                check("mon pc empty",     64'(out_pc),     64'(0));
                check("mon i1 empty",     64'(out_instr1), 64'(0));
                check("mon i2 empty",     64'(out_instr2), 64'(0));
            end else begin
                hd = sb[0];
                check("mon valid1", 64'(out_valid1), 64'(1));
                if (!half_m) begin
                    check("mon valid2", 64'(out_valid2), 64'(1));
                    check("mon pc",     64'(out_pc),     64'(hd.pc));
                    check("mon i1",     64'(out_instr1), 64'(hd.i1));
                    check("mon i2",     64'(out_instr2), 64'(hd.i2));
                end else begin
                    check("mon valid2 half", 64'(out_valid2), 64'(0));
                    check("mon pc half",     64'(out_pc),     64'(32'(hd.pc + 32'd4)));
                    check("mon i1 half",     64'(out_instr1), 64'(hd.i2));
                    check("mon i2 half",     64'(out_instr2), 64'(0));
                end
            end
            if (reset || flush) begin
                sb.delete();
                half_m = 1'b0;
            end else begin
                if (sb.size() > 0) begin
                    if (out_consume == 2'd1 && !half_m) begin
                        half_m = 1'b1;
                    end else if (out_consume == 2'd1 || out_consume == 2'd2) begin
                        void'(sb.pop_front());
                        half_m = 1'b0;
                    end
                end
                if (in_valid && rdy_m) sb.push_back('{in_pc, in_instr1, in_instr2});
            end
        end
    end

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] i1,
                         input logic [31:0] i2, input logic [1:0] c, input logic f);
        in_valid    = v;
        in_pc       = pc;
        in_instr1   = i1;
        in_instr2   = i2;
        out_consume = c;
        flush       = f;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [1:0] c);
        drive(1'b0, 32'h0, 32'h0, 32'h0, c, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0; in_pc = '0; in_instr1 = '0; in_instr2 = '0;
        out_consume = 2'd0; flush = 1'b0;
        idle(2'd0);
        idle(2'd0);
        reset  = 1'b0;
        mon_en = 1'b1;
        check("reset in_ready", 64'(in_ready),   64'(1));
        check("reset valid1",   64'(out_valid1), 64'(0));
        check("reset valid2",   64'(out_valid2), 64'(0));
        check("reset pc",       64'(out_pc),     64'(0));
        check("reset i1",       64'(out_instr1), 64'(0));
        check("reset i2",       64'(out_instr2), 64'(0));

        // single pair, full consume
        drive(1'b1, 32'h100, 32'hAAAA0001, 32'hBBBB0002, 2'd0, 1'b0);
        check("single valid1", 64'(out_valid1), 64'(1));
        check("single valid2", 64'(out_valid2), 64'(1));
        check("single pc",     64'(out_pc),     64'(32'h100));
        idle(2'd2);
        check("single drained", 64'(out_valid1), 64'(0));

        // split issue
        drive(1'b1, 32'h100, 32'hAAAA0001, 32'hBBBB0002, 2'd0, 1'b0);
        idle(2'd1);
        check("split pc",     64'(out_pc),     64'(32'h104));
        check("split i1",     64'(out_instr1), 64'(32'hBBBB0002));
        check("split valid2", 64'(out_valid2), 64'(0));
        idle(2'd1);
        check("split drained", 64'(out_valid1), 64'(0));

        // fill, back-pressure, wrap
        for (int k = 0; k < 4; k++)
            drive(1'b1, 32'h200 + 32'(8 * k), 32'h1000_0000 + 32'(k), 32'h2000_0000 + 32'(k), 2'd0, 1'b0);
        check("full in_ready", 64'(in_ready), 64'(0));
        drive(1'b1, 32'h220, 32'h5A5A0001, 32'h5A5A0002, 2'd0, 1'b0);
        check("full reject ready", 64'(in_ready), 64'(0));
        check("full reject pc",    64'(out_pc),   64'(32'h200));
        drive(1'b1, 32'h220, 32'h5A5A0001, 32'h5A5A0002, 2'd2, 1'b0);
        check("pop frees ready", 64'(in_ready), 64'(1));
        check("pop next pc",     64'(out_pc),   64'(32'h208));
        drive(1'b1, 32'h220, 32'h5A5A0001, 32'h5A5A0002, 2'd0, 1'b0);
        check("refill ready", 64'(in_ready), 64'(0));
        idle(2'd1);
        check("wrap half pc", 64'(out_pc), 64'(32'h20C));
        idle(2'd2);
        check("both on half pc",     64'(out_pc),     64'(32'h210));
        check("both on half valid2", 64'(out_valid2), 64'(1));
        idle(2'd2);
        check("wrap pc 218", 64'(out_pc), 64'(32'h218));
        idle(2'd2);
        check("wrap pc 220", 64'(out_pc),     64'(32'h220));
        check("wrap i1 220", 64'(out_instr1), 64'(32'h5A5A0001));
        idle(2'd2);
        check("wrap drained", 64'(out_valid1), 64'(0));

        // flush priority
        for (int k = 0; k < 3; k++)
            drive(1'b1, 32'h300 + 32'(8 * k), 32'h3000_0000 + 32'(k), 32'h3100_0000 + 32'(k), 2'd0, 1'b0);
        drive(1'b1, 32'h318, 32'h3000_0003, 32'h3100_0003, 2'd2, 1'b1);
        check("flush valid1",   64'(out_valid1), 64'(0));
        check("flush in_ready", 64'(in_ready),   64'(1));
        idle(2'd0);
        check("flush push dropped", 64'(out_valid1), 64'(0));
        drive(1'b1, 32'h400, 32'h4000_0001, 32'h4100_0001, 2'd2, 1'b0);
        check("empty consume ignored", 64'(out_pc), 64'(32'h400));
        drive(1'b1, 32'h408, 32'h4000_0002, 32'h4100_0002, 2'd2, 1'b0);
        check("push+pop pc",    64'(out_pc),   64'(32'h408));
        check("push+pop ready", 64'(in_ready), 64'(1));
        idle(2'd2);
        check("push+pop drained", 64'(out_valid1), 64'(0));

        // PC wrap on the second slot
        drive(1'b1, 32'hFFFF_FFFC, 32'h1111_0000, 32'h2222_0000, 2'd0, 1'b0);
        idle(2'd1);
        check("pcwrap pc", 64'(out_pc),     64'(32'h0));
        check("pcwrap i1", 64'(out_instr1), 64'(32'h2222_0000));
        idle(2'd1);
        check("pcwrap drained", 64'(out_valid1), 64'(0));

        // reset mid-operation, with a push in the reset cycle
        drive(1'b1, 32'h500, 32'h5000_0001, 32'h5100_0001, 2'd0, 1'b0);
        drive(1'b1, 32'h508, 32'h5000_0002, 32'h5100_0002, 2'd1, 1'b0);
        reset = 1'b1;
        drive(1'b1, 32'h600, 32'h6000_0001, 32'h6100_0001, 2'd0, 1'b0);
        reset = 1'b0;
        check("midreset valid1", 64'(out_valid1), 64'(0));
        check("midreset pc",     64'(out_pc),     64'(0));
        check("midreset i1",     64'(out_instr1), 64'(0));
        check("midreset ready",  64'(in_ready),   64'(1));
        idle(2'd0);
        idle(2'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
